// File: rtl/iexecute_pipe.sv
// rtl/iexecute_pipe.sv - LEGv8 execute stage with iterative MUL and valid/ready handshake
//
// Purpose: registered execute stage between ID/EX and EX/MEM. Computes alu_result, zero
// and branch_target. Single-cycle ops complete on the accept edge. MUL runs a shift-add
// loop, one bit per cycle, for WIDTH cycles.
//
// Ports:
//   clk, reset                     clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready            upstream handshake
//   pc_in, read_data1_in,
//   read_data2_in,
//   sign_extended_output_in        instruction PC, operand A, operand B, immediate
//   alu_op_in, alu_src_in,
//   opcode_in                      operation selection
//   out_valid / out_ready          downstream handshake
//   alu_result, zero,
//   branch_target                  registered results
//   busy                           MUL iteration in progress
module iexecute_pipe #(
    parameter int WIDTH  = 64,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] read_data1_in,
    input  logic [WIDTH-1:0] read_data2_in,
    input  logic [WIDTH-1:0] sign_extended_output_in,
    input  logic [1:0]       alu_op_in,
    input  logic             alu_src_in,
    input  logic [10:0]      opcode_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic [WIDTH-1:0] branch_target,
    output logic             busy
);

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;
    localparam logic [10:0] OP_MUL = 11'b10011011000;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] single_result;
    logic [WIDTH-1:0] target_in;
    logic             is_mul;
    logic             accept;
    logic             out_free;
    logic             last_iter;

    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] mul_step;
    logic [WIDTH-1:0] mul_target;
    logic [CW-1:0]    mul_cnt;

    assign op_b      = alu_src_in ? sign_extended_output_in : read_data2_in;
    assign target_in = pc_in + (sign_extended_output_in << 2);
    assign is_mul    = MUL_EN && (alu_op_in == 2'b10) && (opcode_in == OP_MUL);
    assign accept    = in_valid && in_ready;
    // The output slot can take a new result if empty or being consumed this edge.
    assign out_free  = !out_valid || out_ready;
    assign last_iter = (state == S_MUL) && (mul_cnt == CNT_LAST);
    // Partial product for the current multiplier bit; A shifts left as B shifts right.
    assign mul_step  = mul_acc + (mul_b[0] ? mul_a : '0);

    always_comb begin
        single_result = '0;
        case (alu_op_in)
            2'b00: single_result = read_data1_in + op_b;
            2'b01: single_result = op_b;
            2'b10: begin
                case (opcode_in)
                    OP_ADD:  single_result = read_data1_in + op_b;
                    OP_SUB:  single_result = read_data1_in - op_b;
                    OP_AND:  single_result = read_data1_in & op_b;
                    OP_ORR:  single_result = read_data1_in | op_b;
                    default: single_result = '0;
                endcase
            end
            default: single_result = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept && is_mul) state_nxt = S_MUL;
            S_MUL:  if (last_iter) state_nxt = out_free ? S_IDLE : S_HOLD;
            S_HOLD: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State-derived outputs
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        if (!reset) begin
            in_ready = (state == S_IDLE) && out_free;
        end
        busy = (state == S_MUL);
    end

    // Output registers and MUL datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            alu_result    <= '0;
            zero          <= 1'b0;
            branch_target <= '0;
            mul_a         <= '0;
            mul_b         <= '0;
            mul_acc       <= '0;
            mul_target    <= '0;
            mul_cnt       <= '0;
        end else begin
            if (accept && !is_mul) begin
                out_valid     <= 1'b1;
                alu_result    <= single_result;
                zero          <= (single_result == '0);
                branch_target <= target_in;
            end else if (last_iter && out_free) begin
                out_valid     <= 1'b1;
                alu_result    <= mul_step;
                zero          <= (mul_step == '0);
                branch_target <= mul_target;
            end else if ((state == S_HOLD) && out_ready) begin
                // Completed product parked in mul_acc while the slot was occupied.
                out_valid     <= 1'b1;
                alu_result    <= mul_acc;
                zero          <= (mul_acc == '0);
                branch_target <= mul_target;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept && is_mul) begin
                mul_a      <= read_data1_in;
                mul_b      <= op_b;
                mul_acc    <= '0;
                mul_target <= target_in;
                mul_cnt    <= '0;
            end else if (state == S_MUL) begin
                mul_acc <= mul_step;
                mul_a   <= mul_a << 1;
                mul_b   <= mul_b >> 1;
                mul_cnt <= last_iter ? '0 : mul_cnt + 1'b1;
            end
        end
    end

endmodule
